// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with PC register and IF/ID pipeline register
//
// Holds the program counter, presents it to a combinational instruction
// memory and captures the returned word into the IF/ID register. Each
// cycle takes exactly one action, in priority order: redirect, stall,
// advance.
//
// Ports:
//   clk              rising-edge clock for all state
//   rst              synchronous active-high reset
//   imem_addr        byte address to instruction memory (equals pc_q)
//   imem_instr       instruction word returned for imem_addr
//   stall            decode cannot accept; hold PC and IF/ID
//   redirect_valid   taken branch/jump; load redirect_target
//   redirect_target  new PC byte address
//   if_id_valid      IF/ID slot holds a real instruction
//   if_id_pc         PC of the instruction in the slot
//   if_id_pc_plus4   if_id_pc + 4 (modulo 2^32)
//   if_id_instr      instruction in the slot; NOP_INSTR when invalid
//   misalign_err     sticky flag for redirects with nonzero bits [1:0]
//   fetch_count      saturating count of instructions accepted

module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        misalign_err,
   output logic [15:0] fetch_count
);

   // Instructions are word aligned, so the low bits of the reset PC are
   // dropped regardless of how the parameter is set.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0] pc_q;
   logic [31:0] pc_next_seq;

   // Plain 32-bit add: wraps from FFFF_FFFC to 0 without any flag.
   assign pc_next_seq = pc_q + 32'd4;

   // Memory is combinational, so the address is the PC itself.
   assign imem_addr = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q           <= RESET_PC_ALIGNED;
         if_id_valid    <= 1'b0;
         if_id_pc       <= 32'h0000_0000;
         if_id_pc_plus4 <= 32'h0000_0000;
         if_id_instr    <= NOP_INSTR;
         misalign_err   <= 1'b0;
         fetch_count    <= 16'h0000;
      end else if (redirect_valid) begin
         // Redirect wins over stall: the slot becomes a bubble and stays
         // one for as long as stall is held afterwards. PC fields of the
         // slot are left as they were.
         pc_q        <= {redirect_target[31:2], 2'b00};
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if (redirect_target[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
         end
      end else if (!stall) begin
         pc_q           <= pc_next_seq;
         if_id_valid    <= 1'b1;
         if_id_pc       <= pc_q;
         if_id_pc_plus4 <= pc_next_seq;
         if_id_instr    <= imem_instr;
         if (fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
         end
      end
      // stall without redirect: every register holds.
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard testbench for if_fetch_stage

module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        misalign_err;
   logic [15:0] fetch_count;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic [31:0] addr;
      logic [15:0] cnt;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .if_id_instr     (if_id_instr),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count)
   );

   // Instruction memory: 0x11..0x44 at words 0-3, elsewhere C0DE plus low address half.
   always_comb begin
      case (imem_addr)
         32'h0: imem_instr = 32'h11;
         32'h4: imem_instr = 32'h22;
         32'h8: imem_instr = 32'h33;
         32'hC: imem_instr = 32'h44;
         default: imem_instr = {16'hC0DE, imem_addr[15:0]};
      endcase
   end

   task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL vec%0d %s: got %h expected %h", v, name, act, req);
      end
   endtask

   // Monitor: after each edge that had a stimulus vector, compare the slot.
   int mon_no = 0;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("if_id_valid",    mon_no, {31'b0, if_id_valid},  {31'b0, e.valid});
         chk("if_id_pc",       mon_no, if_id_pc,              e.pc);
         chk("if_id_pc_plus4", mon_no, if_id_pc_plus4,        e.pc4);
         chk("if_id_instr",    mon_no, if_id_instr,           e.instr);
         chk("imem_addr",      mon_no, imem_addr,             e.addr);
         chk("fetch_count",    mon_no, {16'b0, fetch_count},  {16'b0, e.cnt});
         chk("misalign_err",   mon_no, {31'b0, misalign_err}, {31'b0, e.mis});
         mon_no++;
      end
   end

   task automatic vec(input logic r, input logic s, input logic rv, input logic [31:0] tgt,
                      input logic ev, input logic [31:0] epc, input logic [31:0] epc4,
                      input logic [31:0] einstr, input logic [31:0] eaddr,
                      input logic [15:0] ecnt, input logic emis);
      exp_t e;
      @(negedge clk);
      #1;
      rst             = r;
      stall           = s;
      redirect_valid  = rv;
      redirect_target = tgt;
      e = '{valid: ev, pc: epc, pc4: epc4, instr: einstr, addr: eaddr, cnt: ecnt, mis: emis};
      exp_q.push_back(e);
      vec_no++;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

      //   rst  stl  rv   target         valid pc             pc+4           instr          addr           cnt       mis
      // Reset, then four straight fetches
      vec(1, 0, 0, 32'h0,          0, 32'h0,        32'h0,        NOP,          32'h0,        16'd0, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h0,        32'h4,        32'h11,       32'h4,        16'd1, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h4,        32'h8,        32'h22,       32'h8,        16'd2, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h8,        32'hC,        32'h33,       32'hC,        16'd3, 0);
      vec(0, 0, 0, 32'h0,          1, 32'hC,        32'h10,       32'h44,       32'h10,       16'd4, 0);
      // Reset, two fetches, stall three cycles
      vec(1, 0, 0, 32'h0,          0, 32'h0,        32'h0,        NOP,          32'h0,        16'd0, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h0,        32'h4,        32'h11,       32'h4,        16'd1, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h4,        32'h8,        32'h22,       32'h8,        16'd2, 0);
      vec(0, 1, 0, 32'h0,          1, 32'h4,        32'h8,        32'h22,       32'h8,        16'd2, 0);
      vec(0, 1, 0, 32'h0,          1, 32'h4,        32'h8,        32'h22,       32'h8,        16'd2, 0);
      vec(0, 1, 0, 32'h0,          1, 32'h4,        32'h8,        32'h22,       32'h8,        16'd2, 0);
      // Redirect to 0x40 together with stall; bubble persists while stalled
      vec(0, 1, 1, 32'h40,         0, 32'h4,        32'h8,        NOP,          32'h40,       16'd2, 0);
      vec(0, 1, 0, 32'h0,          0, 32'h4,        32'h8,        NOP,          32'h40,       16'd2, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h40,       32'h44,       32'hC0DE0040, 32'h44,       16'd3, 0);
      // Misaligned redirect to 0x42; flag is sticky
      vec(0, 0, 1, 32'h42,         0, 32'h40,       32'h44,       NOP,          32'h40,       16'd3, 1);
      vec(0, 0, 0, 32'h0,          1, 32'h40,       32'h44,       32'hC0DE0040, 32'h44,       16'd4, 1);
      // Back-to-back redirects: last one wins, slot stays invalid
      vec(0, 0, 1, 32'h100,        0, 32'h40,       32'h44,       NOP,          32'h100,      16'd4, 1);
      vec(0, 0, 1, 32'h200,        0, 32'h40,       32'h44,       NOP,          32'h200,      16'd4, 1);
      vec(0, 0, 0, 32'h0,          1, 32'h200,      32'h204,      32'hC0DE0200, 32'h204,      16'd5, 1);
      // PC wrap at top of address space
      vec(0, 0, 1, 32'hFFFF_FFFC,  0, 32'h200,      32'h204,      NOP,          32'hFFFF_FFFC,16'd5, 1);
      vec(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,32'h0,        32'hC0DEFFFC, 32'h0,        16'd6, 1);
      vec(0, 0, 0, 32'h0,          1, 32'h0,        32'h4,        32'h11,       32'h4,        16'd7, 1);
      // Reset mid-stream with stall and redirect high; stalled after release
      vec(1, 1, 1, 32'h80,         0, 32'h0,        32'h0,        NOP,          32'h0,        16'd0, 0);
      vec(0, 1, 0, 32'h0,          0, 32'h0,        32'h0,        NOP,          32'h0,        16'd0, 0);
      vec(0, 0, 0, 32'h0,          1, 32'h0,        32'h4,        32'h11,       32'h4,        16'd1, 0);

      // Saturation: 65540 unchecked advances, then one checked advance.
      // pc_q starts at 4, so the checked slot has pc 4+4*65540 = 0x40014.
      stall = 1'b0; redirect_valid = 1'b0; rst = 1'b0;
      repeat (65540) @(negedge clk);
      vec(0, 0, 0, 32'h0,          1, 32'h40014,    32'h40018,    32'hC0DE0014, 32'h40018,    16'hFFFF, 0);

      begin
         int guard;
         guard = 0;
         while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         @(negedge clk);
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] forced to 0.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction driven on if_id_instr whenever the slot is invalid.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to the combinational instruction memory; equals pc_q.
REQ-007 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-008 stall  input  1  decode cannot accept; hold PC and the IF/ID register.
REQ-009 redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-010 redirect_target  input  32  new PC byte address.
REQ-011 if_id_valid  output  1  IF/ID slot holds a real instruction.
REQ-012 if_id_pc  output  32  PC of the instruction in the slot.
REQ-013 if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
REQ-014 if_id_instr  output  32  instruction in the slot; NOP_INSTR when invalid.
REQ-015 misalign_err  output  1  sticky; set when a redirect target has nonzero bits [1:0].
REQ-016 fetch_count  output  16  number of instructions accepted into IF/ID; saturating.

Function
REQ-017 Internal PC register pc_q SHALL drive imem_addr directly, with no registered delay.
REQ-018 Each edge with rst=0 SHALL apply exactly one case, in priority order redirect > stall > advance.
REQ-019 Redirect (redirect_valid=1): pc_q <= {redirect_target[31:2],2'b00}; if_id_valid <= 0; if_id_instr <= NOP_INSTR; if_id_pc and if_id_pc_plus4 hold; fetch_count holds. The case applies even when stall=1.
REQ-020 Redirect with redirect_target[1:0] != 0 SHALL set misalign_err <= 1; misalign_err SHALL clear only on rst.
REQ-021 Stall (stall=1, redirect_valid=0): pc_q, if_id_* and fetch_count SHALL hold their values.
REQ-022 Advance (stall=0, redirect_valid=0): if_id_pc <= pc_q; if_id_instr <= imem_instr; if_id_pc_plus4 <= pc_q+4; if_id_valid <= 1; pc_q <= pc_q+4; fetch_count increments.
REQ-023 Latency SHALL be one cycle: the word at pc_q appears on if_id_instr after the next rising edge that takes the advance case.
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-025 fetch_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-026 A redirect SHALL insert exactly one bubble; the cycle after it fetches from the new target.
REQ-027 Back-to-back redirects SHALL each win; the last target SHALL take effect and if_id_valid SHALL stay 0 throughout.
REQ-028 Asserting stall and redirect in the same cycle SHALL redirect, and the bubble SHALL then persist while stall stays high.
REQ-029 All outputs except imem_addr SHALL be registered; the block SHALL contain no combinational path from stall or redirect_* to any output.

Reset
REQ-030 rst=1 at an edge SHALL set pc_q=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, misalign_err=0 and fetch_count=0, overriding stall and redirect.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight slot; the first advance after release SHALL fetch from RESET_PC.
REQ-032 While rst=1, imem_addr SHALL equal RESET_PC from the first edge onward.

Verification
REQ-033 Reset, then 4 cycles with no stall, imem holding 0x11,0x22,0x33,0x44 at words 0-3 -> if_id_instr sequence 0x11,0x22,0x33,0x44; if_id_pc sequence 0,4,8,C; fetch_count=4.
REQ-034 Stall for 3 cycles after the 2nd fetch -> if_id_pc=4, instr=0x22 held for 3 cycles; imem_addr=8 held; fetch_count=2 held.
REQ-035 redirect_valid=1, target=0x40, with stall=1 in the same cycle -> next cycle if_id_valid=0, instr=NOP_INSTR, imem_addr=0x40; after stall drops, if_id_pc=0x40.
REQ-036 Redirect target=0x42 -> imem_addr=0x40 and misalign_err=1; misalign_err stays 1 through later fetches until rst.
REQ-037 pc_q forced to 32'hFFFF_FFFC, then one advance -> if_id_pc=FFFF_FFFC, if_id_pc_plus4=0, imem_addr=0.
REQ-038 rst pulsed for 1 cycle mid-stream, with stall high -> all outputs at their reset values; the next advance fetches from RESET_PC; fetch_count restarts at 1.
